// File: rtl/adc_stim_gen.sv
// ADC emulator for buck-controller self-test: ramp, steady level, alternating events.
// Define ADC_STIM_NOISE_EN to compile in the LFSR noise path (default: noise = 0).
module adc_stim_gen #(
  parameter int          DW              = 8,
  parameter int          TARGET          = 192,
  parameter int          RAMP_SAMPLES    = 200,
  parameter int          EVT_PERIOD      = 260,
  parameter int          EVT_AMP         = 20,
  parameter int          NOISE_AMP       = 2,
  parameter int          FALLBACK_CYCLES = 500,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          convst_bar,
  output logic [DW-1:0] data_out,
  output logic          sample_valid,
  output logic [1:0]    phase,
  output logic [15:0]   sample_cnt,
  output logic          fallback_active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2,
    EVENT  = 2'd3
  } state_e;

  localparam int SW = DW + 3;
  localparam int WW = $clog2(FALLBACK_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(FALLBACK_CYCLES - 1);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_SAMPLES - 1);
  localparam logic [15:0] EVT_LAST = 16'(EVT_PERIOD - 1);
  localparam bit EVT_EN = (EVT_PERIOD != 0);
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** DW) - 1);
  localparam logic signed [SW-1:0] BASE_T = SW'(TARGET);
  localparam logic signed [SW-1:0] OFF0 = SW'(EVT_AMP);
  localparam logic signed [SW-1:0] OFF1 = SW'(-(EVT_AMP / 2));
  localparam logic signed [SW-1:0] OFF2 = SW'(EVT_AMP / 4);

  if (SEED == 16'h0 || FALLBACK_CYCLES < 4 ||
      RAMP_SAMPLES < 1 || NOISE_AMP < 0) begin : g_bad_cfg
    $error("adc_stim_gen: illegal parameter set");
  end

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q;
  logic [WW-1:0]        wd_q, wd_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          stdy_q, stdy_d;
  logic [1:0]           evt_q, evt_d;
  logic                 par_q, par_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fb_q, fb_d;
  logic                 strobe_req, wd_req, active, upd;
  logic [31:0]          ramp_prod;
  logic [DW-1:0]        ramp_base;
  logic signed [SW-1:0] base, off, noise, sum;
  logic [DW-1:0]        clamped;

`ifdef ADC_STIM_NOISE_EN
  localparam logic [15:0] NMOD = 16'(2 * NOISE_AMP + 1);
  logic [15:0] lfsr_q, lfsr_d, nmod;

  assign nmod  = lfsr_q % NMOD;
  assign noise = $signed(SW'(nmod)) - $signed(SW'(NOISE_AMP));

  // Galois form of x^16+x^14+x^13+x^11+1, stepped once per update
  always_comb begin
    lfsr_d = lfsr_q;
    if (upd)
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign noise = '0;
`endif

  always_comb begin
    strobe_req = sync3_q & ~sync2_q;
    wd_req     = (wd_q == WD_LAST);
    active     = en && (state_q != IDLE);
    upd        = active && (strobe_req || wd_req);

    ramp_prod = 32'(cnt_q) * 32'(TARGET);
    ramp_base = DW'(ramp_prod / 32'(RAMP_SAMPLES));

    unique case (evt_q)
      2'd0:    off = OFF0;
      2'd1:    off = OFF1;
      2'd2:    off = OFF2;
      default: off = '0;
    endcase
    if (par_q) off = -off;
    if (state_q != EVENT) off = '0;

    unique case (state_q)
      RAMP:          base = SW'(ramp_base);
      STEADY, EVENT: base = BASE_T;
      default:       base = '0;
    endcase

    sum = base + off + noise;
    if (sum < 0)         clamped = '0;
    else if (sum > MAXV) clamped = '1;
    else                 clamped = sum[DW-1:0];

    state_d = state_q;
    wd_d    = active ? wd_q + WW'(1) : '0;
    cnt_d   = cnt_q;
    stdy_d  = stdy_q;
    evt_d   = evt_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fb_d    = fb_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      stdy_d  = '0;
      evt_d   = '0;
      par_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = RAMP;
    end else if (upd) begin
      wd_d    = '0;
      data_d  = clamped;
      valid_d = 1'b1;
      fb_d    = wd_req & ~strobe_req;
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      unique case (state_q)
        RAMP: begin
          if (cnt_q == RAMP_LAST) begin
            state_d = STEADY;
            stdy_d  = '0;
          end
        end
        STEADY: begin
          if (EVT_EN && stdy_q == EVT_LAST) begin
            state_d = EVENT;
            stdy_d  = '0;
            evt_d   = '0;
          end else begin
            stdy_d = stdy_q + 16'd1;
          end
        end
        EVENT: begin
          if (evt_q == 2'd2) begin
            state_d = STEADY;
            evt_d   = '0;
            par_d   = ~par_q;
          end else begin
            evt_d = evt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      wd_q    <= '0;
      cnt_q   <= '0;
      stdy_q  <= '0;
      evt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= convst_bar;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      stdy_q  <= stdy_d;
      evt_q   <= evt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fb_q    <= fb_d;
    end
  end

  assign data_out        = data_q;
  assign sample_valid    = valid_q;
  assign phase           = state_q;
  assign sample_cnt      = cnt_q;
  assign fallback_active = fb_q;

endmodule

// File: tb/tb_adc_stim_gen.sv
// Scoreboard bench for adc_stim_gen: ramp, events, watchdog, clamp, re-enable, reset.
// Noise checks run only when ADC_STIM_NOISE_EN is defined.
module tb_adc_stim_gen;

  typedef struct {
    logic [7:0] d;
    logic [1:0] ph;
    logic       fb;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] ph;
    logic       fb;
    int         cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst, convst_bar, en_m, en_h, en_l;
  logic [7:0]  d_m, d_h, d_l;
  logic        sv_m, sv_h, sv_l;
  logic [1:0]  ph_m, ph_h, ph_l;
  logic [15:0] cnt_m, cnt_h, cnt_l;
  logic        fb_m, fb_h, fb_l;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int dbl = 0;
  int last_cyc = 0;
  logic prev_sv = 1'b0;
  exp_t sb[$];
  obs_t obs_m[$], obs_h[$], obs_l[$];
  obs_t mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_stim_gen dut (
    .clk(clk), .rst(rst), .en(en_m), .convst_bar(convst_bar),
    .data_out(d_m), .sample_valid(sv_m), .phase(ph_m),
    .sample_cnt(cnt_m), .fallback_active(fb_m)
  );

  adc_stim_gen #(.TARGET(250), .RAMP_SAMPLES(4), .EVT_PERIOD(3)) dut_h (
    .clk(clk), .rst(rst), .en(en_h), .convst_bar(convst_bar),
    .data_out(d_h), .sample_valid(sv_h), .phase(ph_h),
    .sample_cnt(cnt_h), .fallback_active(fb_h)
  );

  adc_stim_gen #(.TARGET(10), .RAMP_SAMPLES(2), .EVT_PERIOD(2),
                 .EVT_AMP(20)) dut_l (
    .clk(clk), .rst(rst), .en(en_l), .convst_bar(convst_bar),
    .data_out(d_l), .sample_valid(sv_l), .phase(ph_l),
    .sample_cnt(cnt_l), .fallback_active(fb_l)
  );

`ifdef ADC_STIM_NOISE_EN
  logic        en_n;
  logic [7:0]  d_n1, d_n2;
  logic        sv_n1, sv_n2, fb_n1, fb_n2;
  logic [1:0]  ph_n1, ph_n2;
  logic [15:0] cnt_n1, cnt_n2;

  adc_stim_gen #(.RAMP_SAMPLES(4), .EVT_PERIOD(0)) dut_n1 (
    .clk(clk), .rst(rst), .en(en_n), .convst_bar(convst_bar),
    .data_out(d_n1), .sample_valid(sv_n1), .phase(ph_n1),
    .sample_cnt(cnt_n1), .fallback_active(fb_n1)
  );

  adc_stim_gen #(.RAMP_SAMPLES(4), .EVT_PERIOD(0)) dut_n2 (
    .clk(clk), .rst(rst), .en(en_n), .convst_bar(convst_bar),
    .data_out(d_n2), .sample_valid(sv_n2), .phase(ph_n2),
    .sample_cnt(cnt_n2), .fallback_active(fb_n2)
  );
`endif

  always @(negedge clk) begin
    mon.cyc = cyc;
    if (sv_m) begin
      mon.d = d_m; mon.ph = ph_m; mon.fb = fb_m;
      obs_m.push_back(mon);
    end
    if (sv_h) begin
      mon.d = d_h; mon.ph = ph_h; mon.fb = fb_h;
      obs_h.push_back(mon);
    end
    if (sv_l) begin
      mon.d = d_l; mon.ph = ph_l; mon.fb = fb_l;
      obs_l.push_back(mon);
    end
    if (sv_m && prev_sv) dbl++;
    prev_sv = sv_m;
  end

  // Reference waveform: ramp, then (p steady + 3 event) periods, noise off
  function automatic exp_t model(int k, int t, int r, int p, int a);
    exp_t e;
    int j, q, off, v;
    off = 0;
    if (k < r) begin
      v = t * k / r;
      e.ph = (k == r - 1) ? 2'd2 : 2'd1;
    end else begin
      j = k - r;
      q = j % (p + 3);
      v = t;
      if (q >= p) begin
        off = (q == p) ? a : (q == p + 1) ? -(a / 2) : a / 4;
        if ((j / (p + 3)) % 2 == 1) off = -off;
      end
      e.ph = (q >= p - 1 && q <= p + 1) ? 2'd3 : 2'd2;
    end
    v = v + off;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    e.d = 8'(v);
    e.fb = 1'b0;
    return e;
  endfunction

  // Strobe low for 3 cycles; the update lands on the 3rd edge after the fall
  task automatic strobe();
    @(posedge clk); #1 convst_bar = 1'b0;
    repeat (3) @(posedge clk);
    #1 convst_bar = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_m = 1'b0; en_h = 1'b0; en_l = 1'b0;
    convst_bar = 1'b1;
`ifdef ADC_STIM_NOISE_EN
    en_n = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (d_m !== 8'd0 || sv_m !== 1'b0 || ph_m !== 2'd0 ||
        cnt_m !== 16'd0 || fb_m !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: d=%0d v=%0b ph=%0d cnt=%0d fb=%0b, want all 0",
               d_m, sv_m, ph_m, cnt_m, fb_m);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    obs_m.delete(); obs_h.delete(); obs_l.delete();
  endtask

  task automatic test_ramp_events();
    exp_t e;
    obs_t o;
    en_m = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ph_m !== 2'd1 || sv_m !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_entry: ph=%0d v=%0b, want 1/0", ph_m, sv_m);
    end
    for (int k = 0; k < 726; k++) begin
      sb.push_back(model(k, 192, 200, 260, 20));
      strobe();
      vectors++;
      e = sb.pop_front();
      if (obs_m.size() == 0) begin
        miscompares++;
        $display("FAIL ramp_evt k=%0d: no update, want d=%0d", k, e.d);
      end else begin
        o = obs_m.pop_front();
        last_cyc = o.cyc;
        if (o.d !== e.d || o.ph !== e.ph || o.fb !== e.fb) begin
          miscompares++;
          $display("FAIL ramp_evt k=%0d: got d=%0d ph=%0d fb=%0b, want d=%0d ph=%0d fb=%0b",
                   k, o.d, o.ph, o.fb, e.d, e.ph, e.fb);
        end
      end
    end
    vectors++;
    if (cnt_m !== 16'd726) begin
      miscompares++;
      $display("FAIL sample_cnt: got %0d, want 726", cnt_m);
    end
  endtask

  task automatic test_fallback();
    exp_t e;
    obs_t o;
    int w;
    for (int i = 0; i < 3; i++) begin
      e = model(726 + i, 192, 200, 260, 20);
      e.fb = 1'b1;
      w = 0;
      while (obs_m.size() == 0 && w < 600) begin
        @(posedge clk);
        w++;
      end
      vectors++;
      if (obs_m.size() == 0) begin
        miscompares++;
        $display("FAIL watchdog #%0d: no update in 600 cycles", i);
      end else begin
        o = obs_m.pop_front();
        if (o.d !== e.d || o.fb !== e.fb || o.cyc - last_cyc != 500) begin
          miscompares++;
          $display("FAIL watchdog #%0d: got d=%0d fb=%0b gap=%0d, want d=%0d fb=1 gap=500",
                   i, o.d, o.fb, o.cyc - last_cyc, e.d);
        end
        last_cyc = o.cyc;
      end
    end
    sb.push_back(model(729, 192, 200, 260, 20));
    strobe();
    vectors++;
    e = sb.pop_front();
    if (obs_m.size() == 0) begin
      miscompares++;
      $display("FAIL strobe_resume: no update, want d=%0d", e.d);
    end else begin
      o = obs_m.pop_front();
      last_cyc = o.cyc;
      if (o.d !== e.d || o.fb !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_resume: got d=%0d fb=%0b, want d=%0d fb=0",
                 o.d, o.fb, e.d);
      end
    end
    // Time the strobe so its request lands on the watchdog expiry cycle
    e = model(730, 192, 200, 260, 20);
    while (cyc < last_cyc + 497) begin
      @(posedge clk); #1;
    end
    convst_bar = 1'b0;
    repeat (3) @(posedge clk);
    #1 convst_bar = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (obs_m.size() != 1) begin
      miscompares++;
      $display("FAIL coincide_count: got %0d updates, want 1", obs_m.size());
    end
    if (obs_m.size() > 0) begin
      o = obs_m.pop_front();
      vectors++;
      if (o.d !== e.d || o.fb !== 1'b0 || o.cyc != last_cyc + 500) begin
        miscompares++;
        $display("FAIL coincide: got d=%0d fb=%0b gap=%0d, want d=%0d fb=0 gap=500",
                 o.d, o.fb, o.cyc - last_cyc, e.d);
      end
    end
    obs_m.delete();
  endtask

  task automatic test_reenable();
    exp_t e;
    obs_t o;
    en_m = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ph_m !== 2'd0 || d_m !== 8'd192 || cnt_m !== 16'd0) begin
      miscompares++;
      $display("FAIL disable_steady: ph=%0d d=%0d cnt=%0d, want 0/192/0",
               ph_m, d_m, cnt_m);
    end
    en_m = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(k, 192, 200, 260, 20));
      strobe();
      vectors++;
      e = sb.pop_front();
      if (obs_m.size() == 0) begin
        miscompares++;
        $display("FAIL reenable k=%0d: no update, want d=%0d", k, e.d);
      end else begin
        o = obs_m.pop_front();
        if (o.d !== e.d || o.ph !== e.ph) begin
          miscompares++;
          $display("FAIL reenable k=%0d: got d=%0d ph=%0d, want d=%0d ph=%0d",
                   k, o.d, o.ph, e.d, e.ph);
        end
      end
    end
    en_m = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ph_m !== 2'd0 || d_m !== 8'd1 || cnt_m !== 16'd0) begin
      miscompares++;
      $display("FAIL disable_ramp: ph=%0d d=%0d cnt=%0d, want 0/1/0",
               ph_m, d_m, cnt_m);
    end
    en_m = 1'b1;
    @(posedge clk); #1;
    strobe();
    vectors++;
    if (d_m !== 8'd0 || ph_m !== 2'd1 || cnt_m !== 16'd1) begin
      miscompares++;
      $display("FAIL restart_k0: d=%0d ph=%0d cnt=%0d, want 0/1/1",
               d_m, ph_m, cnt_m);
    end
    en_m = 1'b0;
    @(posedge clk); #1;
    obs_m.delete();
  endtask

  task automatic test_clamp_hi_reset();
    exp_t e;
    obs_t o;
    en_h = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back(model(k, 250, 4, 3, 20));
      strobe();
      vectors++;
      e = sb.pop_front();
      if (obs_h.size() == 0) begin
        miscompares++;
        $display("FAIL clamp_hi k=%0d: no update, want d=%0d", k, e.d);
      end else begin
        o = obs_h.pop_front();
        if (o.d !== e.d || o.ph !== e.ph) begin
          miscompares++;
          $display("FAIL clamp_hi k=%0d: got d=%0d ph=%0d, want d=%0d ph=%0d",
                   k, o.d, o.ph, e.d, e.ph);
        end
      end
    end
    // Now mid-EVENT: reset must take effect at the very next edge
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (d_h !== 8'd0 || sv_h !== 1'b0 || ph_h !== 2'd0 ||
        cnt_h !== 16'd0 || fb_h !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_event: d=%0d v=%0b ph=%0d cnt=%0d fb=%0b, want all 0",
               d_h, sv_h, ph_h, cnt_h, fb_h);
    end
    rst = 1'b1;
    en_h = 1'b0;
    @(posedge clk); #1;
    obs_h.delete();
  endtask

  task automatic test_clamp_lo();
    exp_t e;
    obs_t o;
    en_l = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      sb.push_back(model(k, 10, 2, 2, 20));
      strobe();
      vectors++;
      e = sb.pop_front();
      if (obs_l.size() == 0) begin
        miscompares++;
        $display("FAIL clamp_lo k=%0d: no update, want d=%0d", k, e.d);
      end else begin
        o = obs_l.pop_front();
        if (o.d !== e.d || o.ph !== e.ph) begin
          miscompares++;
          $display("FAIL clamp_lo k=%0d: got d=%0d ph=%0d, want d=%0d ph=%0d",
                   k, o.d, o.ph, e.d, e.ph);
        end
      end
    end
    en_l = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vectors++;
    if (dbl !== 0) begin
      miscompares++;
      $display("FAIL valid_double: got %0d back-to-back pulses, want 0", dbl);
    end
  endtask

`ifdef ADC_STIM_NOISE_EN
  task automatic test_noise();
    logic [4:0] seen;
    int nd;
    seen = '0;
    en_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) strobe();
    for (int i = 0; i < 1000; i++) begin
      strobe();
      vectors++;
      if (d_n1 < 8'd190 || d_n1 > 8'd194) begin
        miscompares++;
        $display("FAIL noise_range i=%0d: got %0d, want 190..194", i, d_n1);
      end else begin
        seen[d_n1 - 8'd190] = 1'b1;
      end
      vectors++;
      if (d_n1 !== d_n2) begin
        miscompares++;
        $display("FAIL noise_repeat i=%0d: got %0d vs %0d, want equal", i, d_n1, d_n2);
      end
    end
    nd = $countones(seen);
    vectors++;
    if (nd < 3) begin
      miscompares++;
      $display("FAIL noise_distinct: got %0d values, want >= 3", nd);
    end
    en_n = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_STIM_NOISE_EN
    test_noise();
`else
    test_ramp_events();
    test_fallback();
    test_reenable();
    test_clamp_hi_reset();
    test_clamp_lo();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
